// File: rtl/payload_burst_buffer.sv
// ---------------------------------------------------------------------------
// payload_burst_buffer
//
// Buffers application payload words in a circular FIFO and releases them to
// network_stack as contiguous axiiv/axiid bursts, one burst per UDP frame.
// A burst is PKT_WORDS words, or fewer when a flush asks for the buffered
// remainder. After each burst the block waits at least GAP_CYCLES idle
// cycles before the next first beat so the transmitter can drain.
//
// Optional feature (compile-time macro PAYLOAD_SEQ_EN):
//   defined   : each burst starts with one header beat carrying a sequence
//               number (0 after reset, +1 per burst), followed by the data.
//   undefined : bursts carry data only; no sequence register exists.
//
// Ports
//   clk        in   1                 ethernet clock
//   rst        in   1                 synchronous active-high reset
//   din        in   DATA_SIZE         payload word from source
//   din_valid  in   1                 din qualifier
//   din_ready  out  1                 FIFO not full
//   flush      in   1                 pulse: send the buffered partial burst
//   axiiv      out  1                 burst valid to network_stack (registered)
//   axiid      out  DATA_SIZE         burst data to network_stack (registered)
//   level      out  $clog2(DEPTH)+1   FIFO occupancy in words
//   drop       out  1                 pulse: a word was offered while full
//
// Handshake: a word is accepted on a rising clk edge where din_valid and
// din_ready are both high. din_ready depends only on registered occupancy,
// never on din_valid. A word offered while din_ready is low is discarded and
// drop pulses in the following cycle. The output side has no backpressure:
// once a burst starts, axiiv stays high for every beat of it.
// ---------------------------------------------------------------------------
module payload_burst_buffer #(
    parameter int DATA_SIZE  = 16,
    parameter int PKT_WORDS  = 7,
    parameter int DEPTH      = 32,   // power of 2, at least 2
    parameter int GAP_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_SIZE-1:0]     din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     flush,
    output logic                     axiiv,
    output logic [DATA_SIZE-1:0]     axiid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(PKT_WORDS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] PKT_L   = LW'(PKT_WORDS);
    localparam logic [CW-1:0] PKT_C   = CW'(PKT_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic [LW-1:0]        level_d;
    logic                 flush_pend_q;
    logic                 flush_pend_d;
    logic                 drop_q;
    state_t               state_q;
    logic [CW-1:0]        blen_q;
    logic [CW-1:0]        blen_d;
    logic [CW-1:0]        cnt_q;
    logic [GW-1:0]        gap_cnt_q;
    logic                 axiiv_q;
    logic [DATA_SIZE-1:0] axiid_q;
`ifdef PAYLOAD_SEQ_EN
    logic [DATA_SIZE-1:0] seq_q;
`endif

    logic push;
    logic pop;
    logic start;
    logic data_left;

    assign din_ready = (level_q != DEPTH_L);
    assign level     = level_q;
    assign axiiv     = axiiv_q;
    assign axiid     = axiid_q;
    assign drop      = drop_q;

    always_comb begin
        push      = din_valid && din_ready;
        data_left = (state_q == S_BURST) && (cnt_q < blen_q);
        // A burst may start only from IDLE with the gap counter exhausted.
        start     = (state_q == S_IDLE) && (gap_cnt_q == '0) &&
                    ((level_q >= PKT_L) || (flush_pend_q && (level_q != '0)));
        blen_d    = (level_q < PKT_L) ? level_q[CW-1:0] : PKT_C;
`ifdef PAYLOAD_SEQ_EN
        // The decision cycle emits the header, so data pops only in BURST.
        pop       = data_left;
`else
        // The decision cycle already emits the first data word.
        pop       = start || data_left;
`endif
        level_d   = level_q + LW'(push) - LW'(pop);

        flush_pend_d = flush_pend_q;
        if (start) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end else if (level_q == '0) begin
            // Nothing to send: a pending flush is simply forgotten.
            flush_pend_d = 1'b0;
        end
    end

    // Storage has no reset; resetting the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            flush_pend_q <= 1'b0;
            drop_q       <= 1'b0;
            state_q      <= S_IDLE;
            blen_q       <= '0;
            cnt_q        <= '0;
            gap_cnt_q    <= '0;
            axiiv_q      <= 1'b0;
            axiid_q      <= '0;
`ifdef PAYLOAD_SEQ_EN
            seq_q        <= '0;
`endif
        end else begin
            level_q      <= level_d;
            flush_pend_q <= flush_pend_d;
            drop_q       <= din_valid && !din_ready;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_BURST;
                        blen_q  <= blen_d;
                        axiiv_q <= 1'b1;
`ifdef PAYLOAD_SEQ_EN
                        axiid_q <= seq_q;
                        cnt_q   <= '0;
`else
                        axiid_q <= mem[rd_ptr_q];
                        cnt_q   <= CW'(1);
`endif
                    end else begin
                        axiiv_q <= 1'b0;
                        axiid_q <= '0;
                    end
                end
                S_BURST: begin
                    if (data_left) begin
                        axiiv_q <= 1'b1;
                        axiid_q <= mem[rd_ptr_q];
                        cnt_q   <= cnt_q + CW'(1);
                    end else begin
                        // Last beat has been on the bus for one cycle.
                        axiiv_q <= 1'b0;
                        axiid_q <= '0;
`ifdef PAYLOAD_SEQ_EN
                        seq_q   <= seq_q + 1'b1;
`endif
                        // The IDLE decision cycle is itself idle, so GAP
                        // holds for one cycle fewer than the full gap.
                        if (GAP_CYCLES > 1) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= GW'(GAP_CYCLES - 1);
                        end else begin
                            state_q   <= S_IDLE;
                            gap_cnt_q <= '0;
                        end
                    end
                end
                S_GAP: begin
                    axiiv_q <= 1'b0;
                    axiid_q <= '0;
                    if (gap_cnt_q <= GW'(1)) begin
                        gap_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    axiiv_q <= 1'b0;
                    axiid_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payload_burst_buffer.sv
// ---------------------------------------------------------------------------
// tb_payload_burst_buffer
//
// Reference model: the FIFO is a queue of words, the burst rule is "start when
// at least PKT words are held, or a flush is pending and something is held,
// provided GAP cycles have passed since the last beat"; a burst is the front
// min(level, PKT) words. The model predicts every output for every cycle.
// ---------------------------------------------------------------------------
module tb_payload_burst_buffer;

  localparam int DW    = 16;
  localparam int PKT   = 7;
  localparam int DEPTH = 32;
  localparam int GAP   = 1024;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PAYLOAD_SEQ_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic [DW-1:0] din       = '0;
  logic          din_valid = 1'b0;
  logic          flush     = 1'b0;
  logic          din_ready;
  logic          axiiv;
  logic [DW-1:0] axiid;
  logic [LW-1:0] level;
  logic          drop;

  always #5 clk = ~clk;

  payload_burst_buffer #(
    .DATA_SIZE (DW),
    .PKT_WORDS (PKT),
    .DEPTH     (DEPTH),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .flush    (flush),
    .axiiv    (axiiv),
    .axiid    (axiid),
    .level    (level),
    .drop     (drop)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  logic [DW-1:0] exp_q[$];
  bit            m_valid    = 0;
  bit            m_pend     = 0;
  bit            m_burst    = 0;
  bit            m_have_end = 0;
  int            m_rem      = 0;
  longint        m_cyc      = 0;
  longint        m_last_end = 0;
  logic [DW-1:0] m_seq      = '0;
  logic          exp_v, exp_rdy, exp_drop;
  logic [DW-1:0] exp_d;
  logic [LW-1:0] exp_lvl;

  // ---------------- observation log ----------------
  logic [DW-1:0] obs_q[$];
  int            len_q[$];
  int            gap_q[$];
  int            run_len    = 0;
  int            idle_run   = 0;
  int            drop_cnt   = 0;
  bit            seen_burst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int get_len(input int i);
    if (i < len_q.size()) return len_q[i];
    return -1;
  endfunction

  function automatic int get_gap(input int i);
    if (i < gap_q.size()) return gap_q[i];
    return -1;
  endfunction

  function automatic logic [DW-1:0] get_obs(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 'x;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    int sz;
    int blen;
    bit push_ok;
    bit start;
    sz = exp_q.size();
    m_valid = 1;
    if (rst) begin
      exp_q.delete();
      m_pend = 0; m_burst = 0; m_rem = 0; m_have_end = 0; m_seq = '0;
      exp_v = 1'b0; exp_d = '0; exp_drop = 1'b0; exp_lvl = '0; exp_rdy = 1'b1;
      m_cyc++;
      return;
    end
    push_ok = din_valid && (sz < DEPTH);
    start = 0;
    if (m_burst) begin
      if (m_rem > 0) begin
        exp_v = 1'b1; exp_d = exp_q.pop_front(); m_rem--;
      end else begin
        exp_v = 1'b0; exp_d = '0; m_burst = 0;
        m_have_end = 1; m_last_end = m_cyc;
        m_seq = m_seq + 1'b1;
      end
    end else if ((!m_have_end || m_cyc >= m_last_end + GAP) &&
                 (sz >= PKT || (m_pend && sz > 0))) begin
      start = 1;
      blen = (sz < PKT) ? sz : PKT;
      m_burst = 1;
      exp_v = 1'b1;
`ifdef PAYLOAD_SEQ_EN
      exp_d = m_seq; m_rem = blen;
`else
      exp_d = exp_q.pop_front(); m_rem = blen - 1;
`endif
    end else begin
      exp_v = 1'b0; exp_d = '0;
    end
    if (start) m_pend = 0;
    else if (flush) m_pend = 1;
    else if (sz == 0) m_pend = 0;
    if (push_ok) exp_q.push_back(din);
    exp_drop = din_valid && !push_ok;
    exp_lvl = LW'(exp_q.size());
    exp_rdy = (exp_q.size() != DEPTH);
    m_cyc++;
  endtask

  // Compare, log, then predict the next cycle.
  task automatic monitor_cycle();
    if (m_valid) begin
      check("axiiv", 32'(axiiv), 32'(exp_v));
      check("axiid", 32'(axiid), 32'(exp_d));
      check("level", 32'(level), 32'(exp_lvl));
      check("din_ready", 32'(din_ready), 32'(exp_rdy));
      check("drop", 32'(drop), 32'(exp_drop));
    end
    if (axiiv === 1'b1) begin
      if (run_len == 0 && seen_burst) gap_q.push_back(idle_run);
      obs_q.push_back(axiid);
      run_len++; idle_run = 0; seen_burst = 1;
    end else begin
      if (run_len > 0) begin len_q.push_back(run_len); run_len = 0; end
      idle_run++;
    end
    if (drop === 1'b1) drop_cnt++;
    model_step();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [DW-1:0] d, input logic f);
    din_valid = v; din = d; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic wait_bursts(input int n, input int budget, input string name);
    int c = 0;
    while (len_q.size() < n && c < budget) begin
      step(1'b0, '0, 1'b0);
      c++;
    end
    check(name, 32'(len_q.size() >= n), 32'd1);
  endtask

  task automatic run_tests();
    logic [DW-1:0] t1w [7];
    int ob, lb, gb, dc, idx, w, nb, c, n, dead;

    // Reset values
    rst = 1'b1;
    repeat (3) step(1'b0, '0, 1'b0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);
    check("rst_axiiv", 32'(axiiv), 32'd0);
    check("rst_axiid", 32'(axiid), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);

    // One full burst, fixed pattern
    t1w[0] = 16'hABCD; t1w[1] = 16'h6969; t1w[2] = 16'hFFFF; t1w[3] = 16'h0420;
    t1w[4] = 16'hABCD; t1w[5] = 16'h6969; t1w[6] = 16'hFFFF;
    ob = obs_q.size(); lb = len_q.size();
    for (int i = 0; i < 7; i++) step(1'b1, t1w[i], 1'b0);
    wait_bursts(lb + 1, 100, "t1_burst_seen");
    check("t1_len", 32'(get_len(lb)), 32'(7 + HDR));
`ifdef PAYLOAD_SEQ_EN
    check("t1_hdr", 32'(get_obs(ob)), 32'h0000);
`endif
    for (int i = 0; i < 7; i++) check("t1_data", 32'(get_obs(ob + HDR + i)), 32'(t1w[i]));
    check("t1_level", 32'(level), 32'd0);

    // Partial burst by flush, then flush with empty FIFO
    ob = obs_q.size(); lb = len_q.size();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(16'h1000 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    wait_bursts(lb + 1, GAP + 100, "t2_burst_seen");
    check("t2_len", 32'(get_len(lb)), 32'(3 + HDR));
    for (int i = 0; i < 3; i++) check("t2_data", 32'(get_obs(ob + HDR + i)), 32'h1000 + 32'(i));
    ob = obs_q.size(); lb = len_q.size();
    step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    repeat (GAP + 50) step(1'b0, '0, 1'b0);
    check("t2_noburst_len", 32'(len_q.size()), 32'(lb));
    check("t2_noburst_obs", 32'(obs_q.size()), 32'(ob));
    check("t2_level_one", 32'(level), 32'd1);
    step(1'b0, '0, 1'b1);
    wait_bursts(lb + 1, 100, "t2_single_seen");
    check("t2_single_len", 32'(get_len(lb)), 32'(1 + HDR));
    check("t2_single_data", 32'(get_obs(ob + HDR)), 32'h2222);

    // Two full bursts and the gap between them
    lb = len_q.size(); gb = gap_q.size();
    for (int i = 0; i < 14; i++) step(1'b1, DW'($urandom), 1'b0);
    wait_bursts(lb + 2, 3 * GAP, "t3_bursts_seen");
    check("t3_len0", 32'(get_len(lb)), 32'(7 + HDR));
    check("t3_len1", 32'(get_len(lb + 1)), 32'(7 + HDR));
    check("t3_gap0", 32'(get_gap(gb)), 32'd1024);
    check("t3_gap1", 32'(get_gap(gb + 1)), 32'd1024);

    // Overfill while held in GAP
    ob = obs_q.size(); lb = len_q.size(); dc = drop_cnt;
    for (int i = 0; i < 32; i++) step(1'b1, DW'(16'h4000 + i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b0);
    check("t4_level_full", 32'(level), 32'd32);
    check("t4_ready_low", 32'(din_ready), 32'd0);
    step(1'b0, '0, 1'b0);
    check("t4_drop_once", 32'(drop_cnt - dc), 32'd1);
    wait_bursts(lb + 4, 5 * GAP + 200, "t4_bursts_seen");
    check("t4_level_rest", 32'(level), 32'd4);
    step(1'b0, '0, 1'b1);
    wait_bursts(lb + 5, GAP + 100, "t4_flush_seen");
    idx = ob; w = 0;
    for (int k = 0; k < 5; k++) begin
      idx += HDR;
      n = get_len(lb + k) - HDR;
      for (int j = 0; j < n; j++) begin
        check("t4_data", 32'(get_obs(idx)), 32'h4000 + 32'(w));
        w++; idx++;
      end
    end
    check("t4_word_count", 32'(w), 32'd32);
    dead = 0;
    for (int i = ob; i < obs_q.size(); i++) if (obs_q[i] == 16'hDEAD) dead++;
    check("t4_dropped_absent", 32'(dead), 32'd0);

    // Reset on the third beat
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h5000 + i), 1'b0);
    nb = 0; c = 0;
    while (nb < 3 && c < GAP + 100) begin
      step(1'b0, '0, 1'b0);
      c++;
      if (axiiv === 1'b1) nb++;
    end
    check("t5_third_beat", 32'(nb), 32'd3);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    check("t5_axiiv_low", 32'(axiiv), 32'd0);
    check("t5_level_zero", 32'(level), 32'd0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);
    ob = obs_q.size(); lb = len_q.size();
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h6000 + i), 1'b0);
    wait_bursts(lb + 1, 100, "t5_burst_seen");
    check("t5_len", 32'(get_len(lb)), 32'(7 + HDR));
`ifdef PAYLOAD_SEQ_EN
    check("t6_hdr0", 32'(get_obs(ob)), 32'h0000);
`endif
    for (int i = 0; i < 7; i++) check("t5_data", 32'(get_obs(ob + HDR + i)), 32'h6000 + 32'(i));
    ob = obs_q.size();
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h7000 + i), 1'b0);
    wait_bursts(lb + 2, GAP + 100, "t6_burst_seen");
    check("t6_len", 32'(get_len(lb + 1)), 32'(7 + HDR));
`ifdef PAYLOAD_SEQ_EN
    check("t6_hdr1", 32'(get_obs(ob)), 32'h0001);
`endif
    check("t6_first_data", 32'(get_obs(ob + HDR)), 32'h7000);

    // Randomized traffic, checked cycle by cycle against the model
    for (int blk = 0; blk < 8; blk++) begin
      int rate;
      rate = $urandom_range(1, 30);
      for (int i = 0; i < 2500; i++) begin
        if ($urandom_range(0, 4999) == 0) rst = 1'b1;
        else rst = 1'b0;
        step(1'($urandom_range(0, 99) < rate), DW'($urandom), 1'($urandom_range(0, 299) == 0));
      end
    end
    rst = 1'b0;
    repeat (20) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_cycle();
      end
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
